// File: rtl/fetch_unit_pkg.sv
// Core-wide constants and types shared by the fetch path and the core top level.
package fetch_unit_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_unit_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count and flush.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && (count != FULL_COUNT);

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is deliberately left unreset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential word fetches, buffers returned words with their PCs,
// and handles redirects by flushing the buffer and discarding stale in-flight responses.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic [31:0] debug_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic          run;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   aq_mem [DEPTH];
    logic [AW-1:0] aq_wr;
    logic [AW-1:0] aq_rd;

    logic          accept;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    // Dropped-but-pending responses still occupy a slot, so the budget counts all of inflight.
    assign imem_req_valid = run && !redirect_valid
                            && (({1'b0, count} + {1'b0, inflight}) < DEPTH_X);
    assign accept   = imem_req_valid && imem_req_ready;
    assign rsp_drop = (drop_cnt != '0);
    assign rsp_keep = imem_rsp_valid && !rsp_drop && !redirect_valid;
    assign pop      = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            run      <= 1'b0;
            inflight <= '0;
            drop_cnt <= '0;
            aq_wr    <= '0;
            aq_rd    <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
                drop_cnt <= inflight - CW'(imem_rsp_valid);
                aq_wr    <= '0;
                aq_rd    <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    aq_wr    <= aq_wr + 1'b1;
                end
                if (imem_rsp_valid && rsp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (rsp_keep) begin
                    aq_rd <= aq_rd + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            aq_mem[aq_wr] <= fetch_pc;
        end
    end

    assign push_entry.pc    = aq_mem[aq_rd];
    assign push_entry.instr = imem_rsp_data;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_entry),
        .count     (count)
    );

    assign instr_valid = (count != '0);
    assign instr_data  = head_entry.instr;
    assign instr_pc    = head_entry.pc;
    assign imem_addr   = fetch_pc;
    assign debug_pc    = fetch_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with random latency, scoreboard of expected PCs.
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] debug_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .debug_pc       (debug_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_log[$];
    logic [31:0] exp_tail;
    logic [31:0] exp_fetch_pc;

    int total_checks = 0;
    int bad_checks   = 0;
    int cyc;
    int pops;
    int first_pop_cyc;
    logic [31:0] first_pop_pc;

    int   ready_pct;
    int   cons_pct;
    int   redir_pct;
    int   delay_min;
    int   delay_max;
    logic force_redir;
    logic [31:0] force_target;

    logic        prev_redir;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic        saw_coincide;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return (a ^ 32'hDEAD_BEEF) + 32'h13;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        total_checks++;
        if (actual !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic topUp();
        while (exp_q.size() < 32) begin
            exp_q.push_back(exp_tail);
            exp_tail = exp_tail + 32'd4;
        end
    endtask

    task automatic refillExp(input logic [31:0] start);
        exp_q.delete();
        exp_tail = start;
        topUp();
    endtask

    // Drives every DUT input at the falling edge, including the memory response model.
    task automatic applyStimulus();
        @(negedge clk);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_target;
            force_redir    = 1'b0;
        end else if (int'($urandom_range(99)) < redir_pct) begin
            redirect_valid = 1'b1;
            redirect_pc    = $urandom & 32'h0000_3FFF;
        end else begin
            redirect_valid = 1'b0;
            redirect_pc    = $urandom;
        end
        imem_req_ready = (int'($urandom_range(99)) < ready_pct);
        instr_ready    = (int'($urandom_range(99)) < cons_pct);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instrOf(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
    endtask

    // Samples settled outputs before the rising edge and updates the reference models.
    task automatic sampleCycle();
        logic [31:0] e;
        #1;
        checkOutput("cnt_bound", {63'd0, (dut.count <= DEPTH) && (dut.inflight <= DEPTH)
                                          && (dut.drop_cnt <= DEPTH)}, 64'd1);
        if (prev_redir) begin
            checkOutput("flush_instr_valid", {63'd0, instr_valid}, 64'd0);
        end
        if (prev_pending && !redirect_valid) begin
            checkOutput("req_hold", {31'd0, imem_req_valid, imem_addr}, {31'd0, 1'b1, prev_addr});
        end
        if (redirect_valid && imem_rsp_valid && instr_valid && instr_ready) begin
            saw_coincide = 1'b1;
        end
        if (instr_valid && instr_ready) begin
            e = exp_q.pop_front();
            topUp();
            if (first_pop_cyc < 0) begin
                first_pop_cyc = cyc;
                first_pop_pc  = instr_pc;
            end
            pops++;
            checkOutput("instr_pc", {32'd0, instr_pc}, {32'd0, e});
            checkOutput("instr_data", {32'd0, instr_data}, {32'd0, instrOf(e)});
        end
        if (imem_req_valid && imem_req_ready) begin
            checkOutput("req_addr", {32'd0, imem_addr}, {32'd0, exp_fetch_pc});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
            acc_log.push_back(imem_addr);
            mem_q.push_back('{addr: imem_addr,
                              due: cyc + 1 + int'($urandom_range(delay_max, delay_min))});
            checkOutput("outstanding_bound", {63'd0, mem_q.size() <= DEPTH}, 64'd1);
        end
        if (redirect_valid) begin
            exp_fetch_pc = redirect_pc & 32'hFFFF_FFFC;
            refillExp(exp_fetch_pc);
        end
        prev_redir   = redirect_valid;
        prev_pending = imem_req_valid && !imem_req_ready;
        prev_addr    = imem_addr;
        cyc++;
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            applyStimulus();
            sampleCycle();
        end
    endtask

    // Memory is reset together with the fetch unit, so its pending responses vanish.
    task automatic doReset();
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        mem_q.delete();
        @(negedge clk);
        #1;
        checkOutput("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        checkOutput("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        checkOutput("rst_debug_pc", {32'd0, debug_pc}, {32'd0, RESET_PC});
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
        cyc           = 1;
        pops          = 0;
        first_pop_cyc = -1;
        first_pop_pc  = 32'd0;
        prev_redir    = 1'b0;
        prev_pending  = 1'b0;
        prev_addr     = 32'd0;
        saw_coincide  = 1'b0;
        force_redir   = 1'b0;
        exp_fetch_pc  = RESET_PC;
        acc_log.delete();
        refillExp(RESET_PC);
    endtask

    task automatic setKnobs(input int rdy, input int dmin, input int dmax, input int cons, input int redir);
        ready_pct = rdy;
        delay_min = dmin;
        delay_max = dmax;
        cons_pct  = cons;
        redir_pct = redir;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        instr_ready    = 1'b0;
        cyc            = 0;
        force_redir    = 1'b0;
        force_target   = 32'd0;
        setKnobs(0, 0, 0, 0, 0);

        $display("[TB] streaming fetch, one-cycle memory");
        doReset();
        setKnobs(100, 0, 0, 100, 0);
        runCycles(8);
        checkOutput("first_pop_cycle", 64'(first_pop_cyc), 64'd3);
        checkOutput("stream_pops", 64'(pops), 64'd6);

        $display("[TB] consumer stalled, buffer fills");
        doReset();
        setKnobs(100, 0, 0, 0, 0);
        runCycles(10);
        checkOutput("stall_accepts", 64'(acc_log.size()), 64'(DEPTH));
        checkOutput("stall_req_valid", {63'd0, imem_req_valid}, 64'd0);
        checkOutput("stall_addr", {32'd0, imem_addr}, 64'h10);
        checkOutput("stall_count", 64'(dut.count), 64'(DEPTH));
        checkOutput("stall_head_pc", {32'd0, instr_pc}, 64'h0);

        $display("[TB] redirect with two requests in flight");
        doReset();
        setKnobs(100, 3, 3, 100, 0);
        runCycles(2);
        checkOutput("pre_redir_accepts", 64'(acc_log.size()), 64'd2);
        setKnobs(0, 0, 0, 100, 0);
        force_redir  = 1'b1;
        force_target = 32'h0000_0103;
        first_pop_cyc = -1;
        acc_log.delete();
        runCycles(1);
        setKnobs(100, 0, 0, 100, 0);
        runCycles(12);
        checkOutput("redir_first_addr", {32'd0, (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_0000}, 64'h100);
        checkOutput("redir_first_pc", {32'd0, first_pop_pc}, 64'h100);

        $display("[TB] redirect coinciding with response and pop");
        doReset();
        setKnobs(100, 0, 0, 100, 0);
        runCycles(5);
        force_redir  = 1'b1;
        force_target = 32'h0000_0200;
        saw_coincide = 1'b0;
        runCycles(1);
        checkOutput("coincide", {63'd0, saw_coincide}, 64'd1);
        runCycles(6);

        $display("[TB] address wrap at top of memory");
        force_redir  = 1'b1;
        force_target = 32'hFFFF_FFF9;
        runCycles(1);
        acc_log.delete();
        runCycles(6);
        checkOutput("wrap_n", {63'd0, acc_log.size() >= 3}, 64'd1);
        if (acc_log.size() >= 3) begin
            checkOutput("wrap0", {32'd0, acc_log[0]}, 64'hFFFF_FFF8);
            checkOutput("wrap1", {32'd0, acc_log[1]}, 64'hFFFF_FFFC);
            checkOutput("wrap2", {32'd0, acc_log[2]}, 64'h0000_0000);
        end

        $display("[TB] random traffic with redirects and mid-run reset");
        doReset();
        setKnobs(70, 0, 3, 60, 4);
        runCycles(1500);
        checkOutput("rand_progress_a", {63'd0, pops > 100}, 64'd1);
        doReset();
        setKnobs(60, 0, 4, 70, 3);
        runCycles(1500);
        checkOutput("rand_progress_b", {63'd0, pops > 100}, 64'd1);
        setKnobs(100, 0, 0, 100, 0);
        runCycles(30);
        checkOutput("drain_drop_cnt", 64'(dut.drop_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
